// File: rtl/matrix_loader_pkg.sv
// Shared types and helpers for the RMII matrix stream loader.
// Holds the FSM state encoding, RMII symbol constants and width helper.
package matrix_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DRAIN
    } state_t;

    localparam logic [1:0] PREAMBLE_DIBIT = 2'b10;
    localparam logic [1:0] SFD_DIBIT      = 2'b11;

    // $clog2 clamped so single-entry ranges still get a 1-bit field
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/matrix_stream_loader_byte_assembler.sv
// Packs four RMII dibits (MSB first) into a byte.
// The completed byte is presented combinationally with its last dibit.
module rmii_byte_assembler (
    input  logic       clk,
    input  logic       rst,
    input  logic       crsdv,
    input  logic [1:0] rxd,
    input  logic       clear,
    output logic [7:0] rx_byte,
    output logic       byte_valid
);

    logic [5:0] shift;
    logic [1:0] count;

    // Shift in dibits; idle carrier or an explicit clear restarts alignment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift <= '0;
            count <= '0;
        end else if (clear || !crsdv) begin
            count <= '0;
        end else begin
            shift <= {shift[3:0], rxd};
            count <= count + 2'd1;
        end
    end

    assign rx_byte    = {shift, rxd};
    assign byte_valid = crsdv && !clear && (count == 2'd3);

endmodule

// File: rtl/matrix_stream_loader.sv
// RMII receive loader: finds preamble/SFD, reads a matrix-select header
// and writes the payload row-major into one of several matrix buffers.
module matrix_stream_loader
    import matrix_loader_pkg::*;
#(
    parameter int ELEM_WIDTH   = 16,
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int NUM_MATRICES = 2,
    parameter int PREAMBLE_MIN = 28
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  crsdv,
    input  logic [1:0]                            rxd,
    output logic                                  wr_en,
    output logic [clog2_min1(NUM_MATRICES)-1:0]   wr_sel,
    output logic [clog2_min1(ROWS*COLS)-1:0]      wr_addr,
    output logic [ELEM_WIDTH-1:0]                 wr_data,
    output logic                                  done,
    output logic [clog2_min1(NUM_MATRICES)-1:0]   done_sel,
    output logic                                  err
);

    localparam int SW  = clog2_min1(NUM_MATRICES);
    localparam int AW  = clog2_min1(ROWS*COLS);
    localparam int BPE = ELEM_WIDTH / 8;
    localparam int BW  = clog2_min1(BPE);
    localparam int PW  = $clog2(PREAMBLE_MIN + 1);

    localparam logic [AW-1:0] LAST_ADDR = AW'(ROWS*COLS - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(BPE - 1);
    localparam logic [PW-1:0] PRE_MAX   = PW'(PREAMBLE_MIN);

    state_t                  state, state_n;
    logic [PW-1:0]           pcnt, pcnt_n;
    logic [BW-1:0]           bcnt, bcnt_n;
    logic [AW-1:0]           addr, addr_n;
    logic [ELEM_WIDTH-1:0]   elem, elem_n;
    logic [SW-1:0]           sel, sel_n;
    logic                    wen_n, done_n, err_n;
    logic [7:0]              rx_byte;
    logic                    byte_valid;
    logic                    asm_clear;

    // Byte alignment only matters while a frame is being parsed
    assign asm_clear = (state == IDLE) || (state == DRAIN);

    rmii_byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .crsdv      (crsdv),
        .rxd        (rxd),
        .clear      (asm_clear),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid)
    );

    // FSM state and datapath counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            pcnt  <= '0;
            bcnt  <= '0;
            addr  <= '0;
            elem  <= '0;
            sel   <= '0;
        end else begin
            state <= state_n;
            pcnt  <= pcnt_n;
            bcnt  <= bcnt_n;
            addr  <= addr_n;
            elem  <= elem_n;
            sel   <= sel_n;
        end
    end

    // Next-state logic and the strobes to be registered onto the outputs
    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        bcnt_n  = bcnt;
        addr_n  = addr;
        elem_n  = elem;
        sel_n   = sel;
        wen_n   = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (crsdv && rxd == PREAMBLE_DIBIT) begin
                    pcnt_n = (pcnt == PRE_MAX) ? pcnt : pcnt + 1'b1;
                end else if (crsdv && rxd == SFD_DIBIT && pcnt == PRE_MAX) begin
                    state_n = HEADER;
                    pcnt_n  = '0;
                    bcnt_n  = '0;
                    addr_n  = '0;
                end else begin
                    pcnt_n = '0;
                end
            end
            HEADER: begin
                if (!crsdv) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (byte_valid) begin
                    if (int'(rx_byte) < NUM_MATRICES) begin
                        sel_n   = SW'(rx_byte);
                        state_n = PAYLOAD;
                    end else begin
                        err_n   = 1'b1;
                        state_n = DRAIN;
                    end
                end
            end
            PAYLOAD: begin
                if (!crsdv) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (byte_valid) begin
                    elem_n = ELEM_WIDTH'({elem, rx_byte});
                    if (bcnt == LAST_BYTE) begin
                        bcnt_n = '0;
                        wen_n  = 1'b1;
                        if (addr == LAST_ADDR) begin
                            done_n  = 1'b1;
                            state_n = DRAIN;
                        end else begin
                            addr_n = addr + 1'b1;
                        end
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!crsdv) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered write port and status pulses; address/data/select hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            wr_sel   <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done_sel <= '0;
        end else begin
            wr_en <= wen_n;
            done  <= done_n;
            err   <= err_n;
            if (wen_n) begin
                wr_sel  <= sel;
                wr_addr <= addr;
                wr_data <= elem_n;
            end
            if (done_n) done_sel <= sel;
        end
    end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader: builds a dibit stream plus a
// frame-level expectation table, then checks every output every cycle.
module tb_matrix_stream_loader;

    localparam int EW = 16;
    localparam int R  = 2;
    localparam int C  = 3;
    localparam int NM = 2;
    localparam int PM = 28;
    localparam int NE = R * C;
    localparam int N  = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        crsdv = 1'b0;
    logic [1:0]  rxd = 2'b00;
    logic        wr_en;
    logic [0:0]  wr_sel;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        done;
    logic [0:0]  done_sel;
    logic        err;

    matrix_stream_loader #(
        .ELEM_WIDTH   (EW),
        .ROWS         (R),
        .COLS         (C),
        .NUM_MATRICES (NM),
        .PREAMBLE_MIN (PM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .crsdv    (crsdv),
        .rxd      (rxd),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .done     (done),
        .done_sel (done_sel),
        .err      (err)
    );

    always #5 clk = ~clk;

    // stimulus stream
    bit         s_c [N];
    logic [1:0] s_d [N];
    bit         s_r [N];
    // expected events, indexed by the check slot where they appear
    bit x_en [N];
    bit x_done [N];
    bit x_err [N];
    int x_sel [N];
    int x_addr [N];
    int x_data [N];
    // expected held outputs
    int e_sel [N];
    int e_addr [N];
    int e_data [N];
    int e_dsel [N];

    int n = 0;
    int checks = 0;
    int fails = 0;
    int n_wr = 0;
    int n_done = 0;
    int n_err = 0;
    int first_done_data = -1;
    int first_done_sel = -1;

    task automatic check(input string name, input int k,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s slot %0d: got %0h expected %0h",
                     name, k, act, exp);
        end
    endtask

    task automatic push(input bit c, input logic [1:0] d, input bit r);
        s_c[n] = c;
        s_d[n] = d;
        s_r[n] = r;
        n++;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 3; i >= 0; i--) push(1'b1, b[2*i +: 2], 1'b1);
    endtask

    // last dibit of a byte was slot n-1, so its write shows at slot n
    task automatic note_payload(input int i, input logic [7:0] prev,
                                input logic [7:0] cur, input int hdr);
        if (i % 2 == 1 && i / 2 < NE) begin
            x_en[n]   = 1'b1;
            x_addr[n] = i / 2;
            x_data[n] = {16'd0, prev, cur};
            x_sel[n]  = hdr;
            if (i / 2 == NE - 1) x_done[n] = 1'b1;
        end
    endtask

    task automatic frame(input int npre, input int hdr,
                         input int nbytes, input int b0);
        logic [7:0] prev, cur;
        prev = 8'h00;
        for (int i = 0; i < npre; i++) push(1'b1, 2'b10, 1'b1);
        push(1'b1, 2'b11, 1'b1);
        push_byte(hdr[7:0]);
        if (npre >= PM && hdr >= NM) x_err[n] = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            cur = 8'(b0 + i);
            push_byte(cur);
            if (npre >= PM && hdr < NM) note_payload(i, prev, cur, hdr);
            prev = cur;
        end
        if (npre >= PM && hdr < NM && nbytes < 2 * NE) x_err[n+1] = 1'b1;
        push(1'b0, 2'b00, 1'b1);
    endtask

    // good frame to matrix 1 interrupted by reset after its third write
    task automatic reset_frame();
        logic [7:0] prev, cur;
        prev = 8'h00;
        for (int i = 0; i < 31; i++) push(1'b1, 2'b10, 1'b1);
        push(1'b1, 2'b11, 1'b1);
        push_byte(8'h01);
        for (int i = 0; i < 6; i++) begin
            cur = 8'(i);
            push_byte(cur);
            note_payload(i, prev, cur, 1);
            prev = cur;
        end
        push(1'b1, 2'b01, 1'b1);
        push(1'b1, 2'b01, 1'b1);
        for (int i = 0; i < 3; i++) push(1'b1, 2'b10, 1'b0);
        for (int i = 6; i < 12; i++) push_byte(8'(i));
        push(1'b0, 2'b00, 1'b1);
    endtask

    initial begin
        int hs, ha, hd, hds;
        for (int i = 0; i < 3; i++) push(1'b0, 2'b00, 1'b0);
        push(1'b0, 2'b00, 1'b1);
        frame(31, 8'h01, 12, 0);
        frame(31, 8'h05, 4, 0);
        frame(31, 8'h00, 5, 0);
        frame(10, 8'h01, 12, 0);
        reset_frame();
        frame(31, 8'h00, 12, 0);
        frame(31, 8'h00, 12, 0);
        frame(31, 8'h01, 12, 8'h40);
        for (int i = 0; i < 4; i++) push(1'b0, 2'b00, 1'b1);

        hs = 0; ha = 0; hd = 0; hds = 0;
        for (int k = 0; k < n; k++) begin
            if (!s_r[k]) begin
                hs = 0; ha = 0; hd = 0; hds = 0;
            end else begin
                if (x_en[k]) begin
                    hs = x_sel[k]; ha = x_addr[k]; hd = x_data[k];
                end
                if (x_done[k]) hds = x_sel[k];
            end
            e_sel[k] = hs; e_addr[k] = ha; e_data[k] = hd; e_dsel[k] = hds;
        end

        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst   = s_r[k];
            crsdv = s_c[k];
            rxd   = s_d[k];
            #1;
            check("wr_en", k, {31'd0, wr_en}, {31'd0, x_en[k]});
            check("done", k, {31'd0, done}, {31'd0, x_done[k]});
            check("err", k, {31'd0, err}, {31'd0, x_err[k]});
            check("wr_sel", k, {31'd0, wr_sel}, e_sel[k]);
            check("wr_addr", k, {29'd0, wr_addr}, e_addr[k]);
            check("wr_data", k, {16'd0, wr_data}, e_data[k]);
            check("done_sel", k, {31'd0, done_sel}, e_dsel[k]);
            if (wr_en) n_wr++;
            if (err) n_err++;
            if (done) begin
                n_done++;
                if (first_done_data < 0) begin
                    first_done_data = int'(wr_data);
                    first_done_sel  = int'(done_sel);
                end
            end
        end

        check("total_writes", 0, n_wr, 29);
        check("total_done", 0, n_done, 4);
        check("total_err", 0, n_err, 2);
        check("first_done_data", 0, first_done_data, 32'h0A0B);
        check("first_done_sel", 0, first_done_sel, 1);
        check("final_done_sel", 0, {31'd0, done_sel}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/matrix_stream_loader.md
# matrix_stream_loader

Parametrised RMII-to-matrix-buffer loader. Hunts the preamble/SFD on the 2-bit RMII receive interface and reads a one-byte matrix-select header. It then packs the payload into ELEM_WIDTH-bit elements and issues row-major writes into one of NUM_MATRICES matrix buffers. It sits between the PHY pins and the matrix BRAMs feeding the compute core, and reports frame completion and frame errors.

## Interface
- ELEM_WIDTH, 16: element width in bits; multiple of 8, 8..32.
- ROWS, 4: matrix rows.
- COLS, 4: matrix columns.
- NUM_MATRICES, 2: number of destination buffers (channels).
- PREAMBLE_MIN, 28: minimum consecutive preamble dibits before the SFD is accepted.
- clk  input  1  RMII 50 MHz clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-low.
- crsdv  input  1  RMII carrier-sense/data-valid.
- rxd  input  2  RMII receive dibit.
- wr_en  output  1  one-cycle write strobe.
- wr_sel  output  $clog2(NUM_MATRICES) (min 1)  destination matrix index.
- wr_addr  output  $clog2(ROWS*COLS) (min 1)  row-major element address, row*COLS+col.
- wr_data  output  ELEM_WIDTH  element value.
- done  output  1  one-cycle pulse; the matrix is fully written.
- done_sel  output  same as wr_sel  matrix index for done; holds until the next done.
- err  output  1  one-cycle pulse on a bad header or a short frame.

## Operation
- Asynchronous reset: state IDLE, all counters 0. All outputs are 0, including wr_sel, wr_addr, wr_data and done_sel.
- Preamble dibit is 2'b10. SFD dibit is 2'b11.
- States:
  - IDLE: counts consecutive crsdv=1 and rxd=2'b10 samples, saturating at PREAMBLE_MIN. Any other sample clears the count. When the count is PREAMBLE_MIN and rxd=2'b11, go to HEADER. When the count is below PREAMBLE_MIN and rxd=2'b11, clear the count and stay in IDLE.
  - HEADER: assembles one byte. Bytes are 4 dibits, MSB first: the first dibit goes to bits [7:6]. If the byte is below NUM_MATRICES, latch it as the select and go to PAYLOAD. Otherwise pulse err and go to DRAIN.
  - PAYLOAD: collects ELEM_WIDTH/8 bytes per element, first byte most significant. After each element, issue one write and increment the address. On the write to address ROWS*COLS-1, pulse done and go to DRAIN.
  - DRAIN: ignores all data, including trailing bytes and FCS. The first crsdv=0 sample goes to IDLE.
- crsdv=0 in HEADER or PAYLOAD: pulse err, go to IDLE, discard the partial element. Writes already issued stand.
- crsdv=0 in IDLE clears the preamble count.
- No FCS check. No pause is needed between frames beyond a single crsdv=0 cycle.

## Timing
- Latency: wr_en, wr_data, wr_addr and wr_sel are registered. They are valid the cycle after the edge that samples an element's last dibit.
- done is asserted in the same cycle as the final wr_en.
- err is asserted the cycle after the offending sample.
- Writes are spaced at least 4*ELEM_WIDTH/8 cycles apart, so there is no backpressure and no ready input.
- done and err are never asserted in the same cycle.
- Reset mid-frame: outputs clear immediately with no done or err. The loader resumes preamble hunting after reset release, and the rest of the aborted frame is rejected because it is not a valid preamble.

## Structure
- Shared package matrix_loader_pkg:
  - state enum {IDLE, HEADER, PAYLOAD, DRAIN}.
  - PREAMBLE_DIBIT = 2'b10 and SFD_DIBIT = 2'b11.
  - Width helper function clamping $clog2 to at least 1.
- One sub-module, rmii_byte_assembler:
  - Inputs: clk, rst, crsdv, rxd, a clear input.
  - Outputs: byte[7:0], byte_valid.
  - Cleared on SFD and on crsdv=0.
- The top level holds the FSM, preamble counter, element shift register and address counter.

## Test plan
Configuration for all scenarios: ELEM_WIDTH=16, ROWS=2, COLS=3, NUM_MATRICES=2.
- Good frame: 31×2'b10, then 2'b11, header 0x01, payload bytes 0x00..0x0B. Required: 6 writes with wr_sel=1, addr 0..5, data 0x0001, 0x0203 … 0x0A0B. done pulses with the addr-5 write, done_sel=1, no err.
- Bad header 0x05 after a valid preamble/SFD: one err pulse, no wr_en, back in IDLE after crsdv=0.
- Short frame: header 0x00, then 5 payload bytes, then crsdv=0. Required: writes at addr 0 and 1 only, one err pulse, no done.
- Short preamble (10×2'b10, then 2'b11, then a full payload): no writes, no done, no err.
- Reset asserted after 3 payload writes, then released and a full good frame sent to matrix 0. Required: outputs 0 during reset; the second frame produces 6 writes with wr_sel=0 and one done.
- Back-to-back frames to matrix 0 then matrix 1, with one crsdv=0 cycle between them: 12 writes and two done pulses, done_sel=0 then 1.
